data_memory_arbiter: RTL and testbench

//  Shares one single-port data_memory between two requesters (port 0: load/store unit, port 1: debug/DMA).

---
 rtl/data_memory_arbiter_pkg.sv | 19 +
 rtl/data_memory_arbiter_if.sv | 40 ++++
 rtl/data_memory_arbiter_rr.sv | 21 ++
 rtl/data_memory_arbiter.sv | 129 ++++++++++++
 tb/tb_data_memory_arbiter.sv | 308 ++++++++++++++++++++++++++++++
 5 files changed

// File: rtl/data_memory_arbiter_pkg.sv
// Shared widths, memory size and FSM encoding for the data memory arbiter.
package data_memory_pkg;

  localparam int DATA_ADDR_WIDTH = 16;
  localparam int DATA_WIDTH      = 16;
  localparam int DATA_SIZE       = 1024;
  localparam int NUM_PORTS       = 2;

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_ACCESS = 2'd1,
    ST_RESP   = 2'd2
  } arb_state_e;

  function automatic logic [NUM_PORTS-1:0] port_onehot(input logic id);
    return id ? 2'b10 : 2'b01;
  endfunction

endpackage

// File: rtl/data_memory_arbiter_if.sv
// Requester handshakes plus the single-port memory bus, as seen by the arbiter (slave) and its environment (master).
interface data_memory_arbiter_if
  import data_memory_pkg::*;
#(
  parameter int AW = data_memory_pkg::DATA_ADDR_WIDTH,
  parameter int DW = data_memory_pkg::DATA_WIDTH
);

  logic [NUM_PORTS-1:0]         req_valid;
  logic [NUM_PORTS-1:0]         req_ready;
  logic [NUM_PORTS-1:0]         req_write;
  logic [NUM_PORTS-1:0][AW-1:0] req_addr;
  logic [NUM_PORTS-1:0][DW-1:0] req_wdata;

  logic [NUM_PORTS-1:0]         resp_valid;
  logic [NUM_PORTS-1:0]         resp_ready;
  logic [NUM_PORTS-1:0][DW-1:0] resp_rdata;
  logic [NUM_PORTS-1:0]         resp_exc;

  logic [AW-1:0]                mem_addr;
  logic [DW-1:0]                mem_data_in;
  logic                         mem_write;
  logic [DW-1:0]                mem_data_out;
  logic                         mem_exception;

  modport slave (
    input  req_valid, req_write, req_addr, req_wdata, resp_ready,
           mem_data_out, mem_exception,
    output req_ready, resp_valid, resp_rdata, resp_exc,
           mem_addr, mem_data_in, mem_write
  );

  modport master (
    output req_valid, req_write, req_addr, req_wdata, resp_ready,
           mem_data_out, mem_exception,
    input  req_ready, resp_valid, resp_rdata, resp_exc,
           mem_addr, mem_data_in, mem_write
  );

endinterface

// File: rtl/data_memory_arbiter_rr.sv
// Two-way round-robin pick: a lone requester wins outright, a tie goes to the port not granted last.
module mem_rr_arbiter
  import data_memory_pkg::*;
(
  input  logic [NUM_PORTS-1:0] valid_i,
  input  logic                 last_grant_i,
  output logic                 grant_valid_o,
  output logic                 grant_id_o
);

  always_comb begin
    grant_valid_o = |valid_i;
    case (valid_i)
      2'b01:   grant_id_o = 1'b0;
      2'b10:   grant_id_o = 1'b1;
      2'b11:   grant_id_o = ~last_grant_i;
      default: grant_id_o = 1'b0;
    endcase
  end

endmodule

// File: rtl/data_memory_arbiter.sv
// Shares one single-port data memory between the load/store unit (port 0) and debug/DMA (port 1).
// One access in flight: IDLE accepts, ACCESS drives the memory for one cycle, RESP holds the result.
module data_memory_arbiter
  import data_memory_pkg::*;
#(
  parameter int DATA_ADDR_WIDTH = data_memory_pkg::DATA_ADDR_WIDTH,
  parameter int DATA_WIDTH      = data_memory_pkg::DATA_WIDTH,
  parameter int DATA_SIZE       = data_memory_pkg::DATA_SIZE
)(
  input logic                  clk,
  input logic                  rst,
  data_memory_arbiter_if.slave bus
);

  localparam logic [1:0] S_IDLE   = ST_IDLE;
  localparam logic [1:0] S_ACCESS = ST_ACCESS;
  localparam logic [1:0] S_RESP   = ST_RESP;

  // One extra bit so a DATA_SIZE equal to 2**DATA_ADDR_WIDTH still compares correctly.
  localparam logic [DATA_ADDR_WIDTH:0] SIZE_LIMIT = (DATA_ADDR_WIDTH+1)'(DATA_SIZE);

  logic [1:0]                 state_q, state_d;
  logic                       grant_q, grant_d;
  logic                       last_grant_q, last_grant_d;
  logic                       write_q, write_d;
  logic [DATA_ADDR_WIDTH-1:0] addr_q, addr_d;
  logic [DATA_WIDTH-1:0]      wdata_q, wdata_d;
  logic [DATA_WIDTH-1:0]      rdata_q, rdata_d;
  logic                       exc_q, exc_d;

  logic grant_valid;
  logic grant_id;
  logic in_range;

  mem_rr_arbiter u_rr (
    .valid_i       (bus.req_valid),
    .last_grant_i  (last_grant_q),
    .grant_valid_o (grant_valid),
    .grant_id_o    (grant_id)
  );

  assign in_range = {1'b0, addr_q} < SIZE_LIMIT;

  always_comb begin
    state_d      = state_q;
    grant_d      = grant_q;
    last_grant_d = last_grant_q;
    write_d      = write_q;
    addr_d       = addr_q;
    wdata_d      = wdata_q;
    rdata_d      = rdata_q;
    exc_d        = exc_q;
    case (state_q)
      S_IDLE: begin
        if (grant_valid) begin
          grant_d      = grant_id;
          last_grant_d = grant_id;
          write_d      = bus.req_write[grant_id];
          addr_d       = bus.req_addr[grant_id];
          wdata_d      = bus.req_wdata[grant_id];
          state_d      = S_ACCESS;
        end
      end
      S_ACCESS: begin
        rdata_d = write_q ? '0 : bus.mem_data_out;
        exc_d   = bus.mem_exception | ~in_range;
        state_d = S_RESP;
      end
      S_RESP: begin
        if (bus.resp_ready[grant_q]) begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q      <= S_IDLE;
      grant_q      <= 1'b0;
      last_grant_q <= 1'b1;
      write_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      rdata_q      <= '0;
      exc_q        <= 1'b0;
    end else begin
      state_q      <= state_d;
      grant_q      <= grant_d;
      last_grant_q <= last_grant_d;
      write_q      <= write_d;
      addr_q       <= addr_d;
      wdata_q      <= wdata_d;
      rdata_q      <= rdata_d;
      exc_q        <= exc_d;
    end
  end

  // Outputs are silenced while rst is high so an aborted store never reaches memory.
  always_comb begin
    bus.req_ready   = '0;
    bus.resp_valid  = '0;
    bus.resp_rdata  = '0;
    bus.resp_exc    = '0;
    bus.mem_addr    = '0;
    bus.mem_data_in = '0;
    bus.mem_write   = 1'b0;
    if (!rst) begin
      case (state_q)
        S_IDLE: begin
          bus.req_ready[grant_id] = grant_valid;
        end
        S_ACCESS: begin
          bus.mem_addr    = addr_q;
          bus.mem_data_in = wdata_q;
          bus.mem_write   = write_q & in_range;
        end
        S_RESP: begin
          bus.resp_valid           = port_onehot(grant_q);
          bus.resp_rdata[grant_q]  = rdata_q;
          bus.resp_exc[grant_q]    = exc_q;
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_data_memory_arbiter.sv
// Directed plus randomised checks of data_memory_arbiter with a word-level memory and reference model.
module tb_data_memory_arbiter;
  import data_memory_pkg::*;

  localparam int AW   = 16;
  localparam int DW   = 16;
  localparam int SIZE = 1024;
  localparam logic [AW-1:0] SIZE_W      = 16'd1024;
  localparam logic [AW-1:0] POISON_ADDR = 16'd777;
  localparam logic [DW-1:0] OOR_DATA    = 16'hDEAD;

  typedef struct {
    logic          port;
    logic [DW-1:0] rdata;
    logic          exc;
    int            acceptCycle;
  } expect_t;

  logic clk = 1'b0;
  logic rst;
  int   tests = 0;
  int   fails = 0;
  int   cycle = 0;
  int   readyMode = 0;

  expect_t       expQ[$];
  expect_t       e;
  logic [DW-1:0] memArray [SIZE] = '{default: '0};
  logic [DW-1:0] refMem   [SIZE] = '{default: '0};
  int            accCnt [2] = '{0, 0};
  int            accCycle [2] = '{0, 0};
  int            memWrCnt = 0;
  logic          busy = 1'b0;
  logic          lastGrant = 1'b1;
  logic          respSeen = 1'b0;
  int            curAccept = 0;
  logic          curWrite = 1'b0;
  logic [AW-1:0] curAddr = '0;
  logic [DW-1:0] curWdata = '0;
  logic [1:0]    expReady;
  logic          inAccess;
  int            p;
  logic [DW-1:0] rd;
  logic          ex;
  int            wrBefore;

  always #5 clk = ~clk;
  always @(posedge clk) cycle <= cycle + 1;

  data_memory_arbiter_if #(.AW(AW), .DW(DW)) bus();

  data_memory_arbiter #(
    .DATA_ADDR_WIDTH (AW),
    .DATA_WIDTH      (DW),
    .DATA_SIZE       (SIZE)
  ) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  // Stand-in for data_memory: combinational read, faults out of range and on one poisoned word.
  assign bus.mem_data_out  = (bus.mem_addr < SIZE_W) ? memArray[bus.mem_addr[9:0]] : OOR_DATA;
  assign bus.mem_exception = (bus.mem_addr >= SIZE_W) || (bus.mem_addr == POISON_ADDR);
  always @(posedge clk) begin
    if (bus.mem_write && bus.mem_addr < SIZE_W) memArray[bus.mem_addr[9:0]] <= bus.mem_data_in;
  end

  task automatic checkOutput(input string name, input logic [31:0] actual, input logic [31:0] expected);
    tests++;
    if (actual !== expected) begin
      fails++;
      $display("[TB] FAIL %s: got %0h, expected %0h (cycle %0d)", name, actual, expected, cycle);
    end
  endtask

  task automatic refAccess(input logic w, input logic [AW-1:0] a, input logic [DW-1:0] d,
                           output logic [DW-1:0] rdata, output logic exc);
    logic inRange;
    inRange = (a < SIZE_W);
    exc = !inRange || (a == POISON_ADDR);
    if (w) begin
      rdata = '0;
      if (inRange) refMem[a[9:0]] = d;
    end else begin
      rdata = inRange ? refMem[a[9:0]] : OOR_DATA;
    end
  endtask

  // Presents a request and holds it until the monitor sees it accepted; call at posedge+1.
  task automatic applyStimulus(input int port, input logic w, input logic [AW-1:0] a,
                               input logic [DW-1:0] d, input int budget);
    int startCnt;
    int waited;
    startCnt = accCnt[port];
    waited = 0;
    bus.req_valid[port] = 1'b1;
    bus.req_write[port] = w;
    bus.req_addr[port]  = a;
    bus.req_wdata[port] = d;
    while (accCnt[port] == startCnt && waited < budget) begin
      @(posedge clk); #1;
      waited++;
    end
    bus.req_valid[port] = 1'b0;
    if (accCnt[port] == startCnt) checkOutput("accept_timeout", 32'(0), 32'(1));
  endtask

  task automatic waitCycles(input int n);
    repeat (n) begin @(posedge clk); #1; end
  endtask

  function automatic logic [AW-1:0] randAddr();
    logic [AW-1:0] a;
    case ($urandom_range(0, 9))
      0, 1, 2, 3, 4: a = AW'($urandom_range(0, 15));
      5:       a = 16'd1023;
      6:       a = 16'd1024;
      7:       a = 16'hFFFF;
      8:       a = POISON_ADDR;
      default: a = AW'($urandom);
    endcase
    return a;
  endfunction

  initial begin
    bus.resp_ready = 2'b11;
    forever begin
      @(posedge clk); #1;
      case (readyMode)
        1:       bus.resp_ready = 2'($urandom_range(0, 3));
        2:       bus.resp_ready = 2'b10;
        default: bus.resp_ready = 2'b11;
      endcase
    end
  end

  // Monitor: arbitration, memory-bus and response checks against the transaction-level model.
  always @(negedge clk) begin
    if (rst) begin
      checkOutput("rst_req_ready", 32'(bus.req_ready), 32'(0));
      checkOutput("rst_resp_valid", 32'(bus.resp_valid), 32'(0));
      checkOutput("rst_mem_write", 32'(bus.mem_write), 32'(0));
      checkOutput("rst_mem_addr", 32'(bus.mem_addr), 32'(0));
      expQ.delete();
      busy = 1'b0;
      lastGrant = 1'b1;
      respSeen = 1'b0;
    end else begin
      expReady = 2'b00;
      if (!busy) begin
        if (bus.req_valid == 2'b11) expReady = lastGrant ? 2'b01 : 2'b10;
        else expReady = bus.req_valid;
      end
      checkOutput("req_ready", 32'(bus.req_ready), 32'(expReady));

      inAccess = busy && (cycle == curAccept + 1);
      checkOutput("mem_write", 32'(bus.mem_write), 32'(inAccess && curWrite && curAddr < SIZE_W));
      checkOutput("mem_addr", 32'(bus.mem_addr), inAccess ? 32'(curAddr) : 32'(0));
      checkOutput("mem_data_in", 32'(bus.mem_data_in), inAccess ? 32'(curWdata) : 32'(0));
      if (bus.mem_write) memWrCnt++;

      if (bus.resp_valid != 2'b00) begin
        if (expQ.size() == 0) begin
          checkOutput("resp_unexpected", 32'(bus.resp_valid), 32'(0));
        end else begin
          e = expQ[0];
          checkOutput("resp_port", 32'(bus.resp_valid), e.port ? 32'(2) : 32'(1));
          checkOutput("resp_rdata", 32'(bus.resp_rdata[e.port]), 32'(e.rdata));
          checkOutput("resp_exc", 32'(bus.resp_exc[e.port]), 32'(e.exc));
          if (!respSeen) begin
            checkOutput("resp_latency", 32'(cycle - e.acceptCycle), 32'(2));
            respSeen = 1'b1;
          end
          if (bus.resp_ready[e.port]) begin
            void'(expQ.pop_front());
            busy = 1'b0;
            respSeen = 1'b0;
          end
        end
      end else if (busy && (respSeen || cycle - curAccept > 2)) begin
        checkOutput("resp_missing", 32'(bus.resp_valid), respSeen ? 32'(0) : 32'(1));
        if (expQ.size() != 0) void'(expQ.pop_front());
        busy = 1'b0;
        respSeen = 1'b0;
      end

      if ((bus.req_valid & bus.req_ready) != 2'b00) begin
        p = bus.req_ready[1] ? 1 : 0;
        refAccess(bus.req_write[p], bus.req_addr[p], bus.req_wdata[p], rd, ex);
        e.port = 1'(p);
        e.rdata = rd;
        e.exc = ex;
        e.acceptCycle = cycle;
        expQ.push_back(e);
        busy = 1'b1;
        lastGrant = 1'(p);
        curAccept = cycle;
        curWrite = bus.req_write[p];
        curAddr = bus.req_addr[p];
        curWdata = bus.req_wdata[p];
        accCnt[p] = accCnt[p] + 1;
        accCycle[p] = cycle;
      end
    end
  end

  initial begin
    int c1;
    int c2;
    int c3;
    bus.req_valid = '0;
    bus.req_write = '0;
    bus.req_addr  = '0;
    bus.req_wdata = '0;
    rst = 1'b1;
    repeat (3) @(posedge clk);
    #1 rst = 1'b0;

    // Ties: port 0 wins first after reset, then the grant alternates.
    fork
      applyStimulus(0, 1'b0, 16'd2, '0, 20);
      applyStimulus(1, 1'b0, 16'd3, '0, 20);
    join
    checkOutput("tie_after_reset_p0_first", 32'(accCycle[0] < accCycle[1]), 32'(1));
    applyStimulus(0, 1'b0, 16'd4, '0, 20);
    fork
      applyStimulus(0, 1'b0, 16'd5, '0, 20);
      applyStimulus(1, 1'b0, 16'd6, '0, 20);
    join
    checkOutput("tie_alternates_p1_first", 32'(accCycle[1] < accCycle[0]), 32'(1));

    // Store then load at address 0.
    waitCycles(3);
    wrBefore = memWrCnt;
    applyStimulus(0, 1'b1, 16'd0, 16'd100, 20);
    waitCycles(3);
    checkOutput("store_one_write_pulse", 32'(memWrCnt - wrBefore), 32'(1));
    checkOutput("store_reached_memory", 32'(memArray[0]), 32'(100));
    applyStimulus(0, 1'b0, 16'd0, '0, 20);

    // Out-of-range store faults without touching memory; the boundary word is unaffected.
    applyStimulus(1, 1'b1, 16'd1023, 16'h1234, 20);
    waitCycles(3);
    wrBefore = memWrCnt;
    applyStimulus(1, 1'b1, 16'd1024, 16'd55, 20);
    waitCycles(3);
    checkOutput("oor_store_no_write", 32'(memWrCnt - wrBefore), 32'(0));
    applyStimulus(1, 1'b0, 16'd1023, '0, 20);
    applyStimulus(0, 1'b0, 16'hFFFF, '0, 20);
    applyStimulus(0, 1'b1, POISON_ADDR, 16'h0BAD, 20);
    applyStimulus(1, 1'b0, POISON_ADDR, '0, 20);

    // Stalled response on port 0 blocks port 1 until the handshake.
    waitCycles(3);
    readyMode = 2;
    applyStimulus(0, 1'b0, 16'd0, '0, 20);
    fork
      applyStimulus(1, 1'b0, 16'd1, '0, 40);
      begin waitCycles(7); readyMode = 0; end
    join
    checkOutput("stall_blocks_port1", 32'(accCycle[1] > accCycle[0] + 7), 32'(1));

    // Reset while the access is on the memory bus, then retry.
    waitCycles(3);
    applyStimulus(0, 1'b0, 16'd0, '0, 20);
    rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    waitCycles(4);
    applyStimulus(0, 1'b0, 16'd0, '0, 20);

    // Back-to-back stores to one word, then a load; one accept every third cycle.
    waitCycles(3);
    applyStimulus(0, 1'b1, 16'd5, 16'd7, 20);
    c1 = accCycle[0];
    applyStimulus(0, 1'b1, 16'd5, 16'd9, 20);
    c2 = accCycle[0];
    applyStimulus(0, 1'b0, 16'd5, '0, 20);
    c3 = accCycle[0];
    checkOutput("throughput_gap1", 32'(c2 - c1), 32'(3));
    checkOutput("throughput_gap2", 32'(c3 - c2), 32'(3));

    // Random traffic from both requesters with random response back-pressure.
    readyMode = 1;
    fork
      begin
        for (int k0 = 0; k0 < 40; k0++) begin
          waitCycles($urandom_range(0, 2));
          applyStimulus(0, 1'($urandom_range(0, 1)), randAddr(), DW'($urandom), 200);
        end
      end
      begin
        for (int k1 = 0; k1 < 40; k1++) begin
          waitCycles($urandom_range(0, 2));
          applyStimulus(1, 1'($urandom_range(0, 1)), randAddr(), DW'($urandom), 200);
        end
      end
    join

    readyMode = 0;
    for (int w = 0; w < 20 && expQ.size() != 0; w++) waitCycles(1);
    checkOutput("drain_empty", 32'(expQ.size()), 32'(0));

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
